ps2_rx_deframer: RTL and testbench
==================================

# ps2_rx_deframer

Receives the raw PS/2 keyboard clock and data lines and produces one byte per 11-bit device-to-host frame, strobed for one clk cycle. It sits directly upstream of the keyboard matrix block, which consumes `data`/`valid`. That consumer tracks 0xE0 extended-key and 0xF0 break prefixes itself, so this block passes every byte through uninterpreted. The block handles synchronisation of the asynchronous PS/2 lines, clock glitch filtering, frame checking and stuck-frame recovery.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level (≥2).
- `TIMEOUT_CYCLES`, default 20000: clk cycles without a filtered falling edge, while mid-frame, after which the frame is aborted (≈2 ms at 10 MHz).
- `clk`  in  1  system clock. Reset is `reset`, synchronous, active-high, clocked by `clk`.
- `reset`  in  1  synchronous active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data, asynchronous, idle high.
- `data`  out  8  last correctly received byte; holds until the next good frame.
- `valid`  out  1  one-cycle strobe; `data` is new and valid in that cycle.
- `error`  out  1  one-cycle strobe for a bad parity, a bad stop bit, or a timeout.

## Operation
- Both inputs pass through a 2-flop synchroniser. The synchronised data line is used unfiltered.
- Glitch filter on the synchronised clock:
  - Counter of consecutive samples that differ from the current filtered level.
  - When the count reaches `FILTER_LEN`, the filtered level flips and the counter clears.
  - Any sample equal to the filtered level clears the counter.
  - Filtered level resets to 1.
- Edge detect: the registered filtered level is compared to its previous value, giving a one-cycle `fall` pulse on each 1→0 transition.
- Frame: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). The synchronised data line is sampled on each `fall`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA with bit count 0. On `fall` with data=1 (false start), stay in IDLE with no error.
  - DATA: on each `fall`, shift the sample into bit [count]. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE.
    - If the stop bit is 1 and XOR(8 data bits, parity) = 1: load `data`, pulse `valid`.
    - Otherwise: pulse `error`; `data` is unchanged.
- Timeout counter:
  - Clears on every `fall` and whenever the FSM is in IDLE.
  - Increments each cycle in any other state.
  - On reaching `TIMEOUT_CYCLES`: FSM goes to IDLE, `error` pulses once, the partial byte is discarded.
- `valid` and `error` are never asserted in the same cycle.
- Simultaneous timeout and `fall` in the same cycle: the `fall` wins, and the counter clears.
- Reset, including mid-frame: FSM to IDLE, bit count 0, shift register 0, timeout counter 0, filter counter 0, filtered level 1, synchronisers 1, `data`=0x00, `valid`=0, `error`=0.

## Timing
- `valid`/`error` for a completed frame rise exactly `FILTER_LEN`+4 clk cycles after the raw `ps2_clk` falling edge of the stop bit. This assumes the line is held stable for the whole interval.
- `valid`/`error` last exactly 1 cycle. `data` changes in the same cycle `valid` rises.
- Minimum PS/2 half-period accepted: `FILTER_LEN`+2 clk cycles. Shorter pulses are treated as glitches and ignored.
- Timeout `error` rises `TIMEOUT_CYCLES`+1 cycles after the last `fall` pulse.
- Back-to-back frames need no idle gap beyond the stop bit. The next start-bit `fall` is accepted in the cycle after the return to IDLE.
- No backpressure: the consumer must accept `valid` in the cycle it occurs.

## Test plan
- Frame 0x1C (parity 0, stop 1) at 12.5 kHz PS/2 clock, clk 10 MHz -> single `valid` pulse with `data`=0x1C, `error`=0, latency `FILTER_LEN`+4 from the stop-bit edge.
- Frames 0xE0, 0xF0, 0x75 back-to-back -> three `valid` pulses carrying 0xE0, 0xF0, 0x75 in order; no `error`.
- Frame 0x1C with parity bit 1 -> one `error` pulse, no `valid`, `data` still holds the previous byte. Repeat with stop bit 0 -> same result.
- `ps2_clk` low glitch of `FILTER_LEN`-1 cycles while idle, then the same glitch mid-frame -> no state change. The following frame 0x5A is received correctly.
- Frame cut after 4 data bits, lines left high -> `error` exactly `TIMEOUT_CYCLES`+1 cycles after the last `fall`. A subsequent frame 0x29 gives `valid` with `data`=0x29.
- `reset` asserted for 1 cycle after 6 bits of a frame -> next cycle shows `data`=0x00, `valid`=0, `error`=0, FSM in IDLE. The remaining bits of that frame produce no `valid`. The next full frame 0x16 is received correctly.

Source files
------------

// File: rtl/ps2_rx_deframer.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 lines,
// checks each 11-bit frame and strobes out one byte per good frame.
module ps2_rx_deframer #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       error
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          state;
   logic [1:0]      clk_sync;
   logic [1:0]      data_sync;
   logic [FW-1:0]   fcnt;
   logic            level;
   logic            level_q;
   logic            fall;
   logic [2:0]      bcnt;
   logic [7:0]      shreg;
   logic            par;
   logic [TW-1:0]   tcnt;
   logic            sd;

   assign sd = data_sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Level only flips after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt    <= '0;
         level   <= 1'b1;
         level_q <= 1'b1;
         fall    <= 1'b0;
      end else begin
         if (clk_sync[1] == level) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            level <= clk_sync[1];
            fcnt  <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
         level_q <= level;
         fall    <= level_q & ~level;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bcnt  <= '0;
         shreg <= '0;
         par   <= 1'b0;
         tcnt  <= '0;
         data  <= '0;
         valid <= 1'b0;
         error <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         if (fall) begin
            tcnt <= '0;
            unique case (state)
               IDLE: begin
                  if (!sd) begin
                     state <= DATA;
                     bcnt  <= '0;
                  end
               end
               DATA: begin
                  shreg[bcnt] <= sd;
                  bcnt        <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= sd;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (sd && ((^shreg) ^ par)) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            tcnt <= '0;
         end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stuck frame: drop the partial byte and resync on next start
            state <= IDLE;
            error <= 1'b1;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Randomised bench for ps2_rx_deframer: frames are built bit by bit and the
// expected strobes (kind, byte, cycle) are derived from the frame rules.
module tb_ps2_rx_deframer;

   localparam int F = 8;
   localparam int T = 300;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       error;

   ps2_rx_deframer #(
      .FILTER_LEN(F),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .data(data),
      .valid(valid),
      .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      bit         err;
      logic [7:0] d;
   } ev_t;

   ev_t        expq[$];
   logic [7:0] last_good = 8'h00;
   int         last_fall = 0;
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!reset && (valid || error)) begin
         check("excl", {31'd0, valid && error}, 32'd0);
         if (expq.size() == 0) begin
            check("spurious", {30'd0, valid, error}, 32'd0);
         end else begin
            e = expq.pop_front();
            check("cycle", cyc, e.at);
            check("kind", {31'd0, error}, {31'd0, e.err});
            check("data", {24'd0, data}, {24'd0, e.d});
         end
      end
   end

   // Sends frame bits [first..last]; only a whole frame predicts a strobe
   task automatic send(input logic [7:0] d, input bit bad_par,
                       input bit bad_stop, input int first,
                       input int last, input int glitch_at);
      logic [10:0] b;
      int          hp;
      bit          good;
      ev_t         e;
      b[0]   = 1'b0;
      b[8:1] = d;
      b[9]   = ~(^d) ^ bad_par;
      b[10]  = ~bad_stop;
      for (int i = first; i <= last; i++) begin
         hp = $urandom_range(14, 40);
         ps2_data = b[i];
         tick(hp);
         if (i == glitch_at) begin
            ps2_clk = 1'b0;
            tick(F - 1);
            ps2_clk = 1'b1;
            tick(hp);
         end
         ps2_clk = 1'b0;
         last_fall = cyc;
         if (i == 10 && first == 0) begin
            good = b[10] && ((^d) ^ b[9]);
            if (good) last_good = d;
            e.at  = last_fall + F + 4;
            e.err = !good;
            e.d   = last_good;
            expq.push_back(e);
         end
         tick(hp);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic frame(input logic [7:0] d, input bit bp, input bit bs);
      send(d, bp, bs, 0, 10, -1);
   endtask

   initial begin
      ev_t e;
      tick(3);
      reset = 1'b0;
      tick(1);
      #4;
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      tick(5);

      frame(8'h1C, 0, 0);
      tick(30);
      frame(8'hE0, 0, 0);
      frame(8'hF0, 0, 0);
      frame(8'h75, 0, 0);
      tick(30);

      frame(8'h1C, 1, 0);
      tick(30);
      frame(8'h1C, 0, 1);
      tick(30);

      ps2_clk = 1'b0;
      tick(F - 1);
      ps2_clk = 1'b1;
      tick(30);
      send(8'h5A, 0, 0, 0, 10, 4);
      tick(30);

      send(8'h3C, 0, 0, 0, 4, -1);
      e.at  = last_fall + F + T + 4;
      e.err = 1'b1;
      e.d   = last_good;
      expq.push_back(e);
      tick(T + 60);
      frame(8'h29, 0, 0);
      tick(30);

      send(8'hE7, 0, 0, 0, 5, -1);
      tick(10);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      #4;
      check("mid_rst_data", {24'd0, data}, 32'd0);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_error", {31'd0, error}, 32'd0);
      last_good = 8'h00;
      @(posedge clk);
      #1;
      send(8'hE7, 0, 0, 6, 10, -1);
      tick(T + 50);
      frame(8'h16, 0, 0);
      tick(30);

      for (int k = 0; k < 10; k++) begin
         frame(8'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0);
         if ($urandom % 2 == 0) tick($urandom_range(1, 50));
      end

      tick(T + 50);
      check("pending", expq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
